// File: rtl/clk_period_meter_pkg.sv
// Shared types for the clock period meter: FSM state encoding.
package clk_period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus delay register producing single-cycle rise/fall strobes.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 is the previous s2 for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign o_level = s2;
    assign o_rise  = s2 & ~s3;
    assign o_fall  = ~s2 & s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period (rise to rise) and high time of an asynchronous divided clock,
// flags a match against the expected ratio and a timeout when the input stalls.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int EXP_DIV     = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_match,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] EXP_VAL     = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    meter_state_t state;
    meter_state_t state_next;

    logic             sig_level;
    logic             sig_rise;
    logic             sig_fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hlat;
    logic             arm;
    logic             capture;
    logic             timeout_hit;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_sig   (i_sig),
        .o_level (sig_level),
        .o_rise  (sig_rise),
        .o_fall  (sig_fall)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sig_rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!sig_rise && (cnt == TIMEOUT_VAL)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A rise in the timeout cycle wins: capture takes priority over timeout_hit
    always_comb begin
        arm         = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    arm = sig_rise;
            MEASURE: begin
                capture     = sig_rise;
                timeout_hit = !sig_rise && (cnt == TIMEOUT_VAL);
            end
            default: begin
                arm = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            hlat      <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_match   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            if (arm || capture) begin
                cnt  <= CNT_ONE;
                hcnt <= CNT_ONE;
            end else if (state == MEASURE) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
                if (sig_level && (hcnt != CNT_MAX)) begin
                    hcnt <= hcnt + CNT_ONE;
                end
            end

            if ((state == MEASURE) && sig_fall) begin
                hlat <= hcnt;
            end

            if (capture) begin
                o_period  <= cnt;
                o_high    <= hlat;
                o_match   <= (cnt == EXP_VAL);
                o_valid   <= 1'b1;
                o_timeout <= 1'b0;
            end else if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table-driven waveforms scored through a queue,
// plus hand sequences for timeout, async reset and edge jitter.
module tb_clk_period_meter;

    localparam int CNT_W       = 16;
    localparam int EXP_DIV     = 7;
    localparam int TIMEOUT_CYC = 20;

    typedef struct {
        int high;
        int low;
        int reps;
        int exp_period;
        int exp_high;
        bit exp_match;
    } vec_t;

    typedef struct {
        int period;
        int high;
        bit match;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_sig;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high;
    logic             o_valid;
    logic             o_match;
    logic             o_timeout;

    exp_t sb[$];
    exp_t pending;
    exp_t got;
    bit   armed;
    bit   jitter_mode;
    int   checks;
    int   fails;
    int   jit_sum;
    int   jit_count;
    vec_t tbl[6];

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .EXP_DIV     (EXP_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_sig     (i_sig),
        .o_period  (o_period),
        .o_high    (o_high),
        .o_valid   (o_valid),
        .o_match   (o_match),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d at %0t", name, actual, lo, hi, $time);
        end
    endtask

    // One clk-aligned period starting with a rise; the rise closes the previous period
    task automatic apply_stimulus(input int h, input int l, input int ep, input int eh, input bit em);
        if (armed) sb.push_back(pending);
        armed   = 1'b1;
        pending = '{ep, eh, em};
        i_sig = 1'b1;
        repeat (h) @(posedge i_clk);
        #2 i_sig = 1'b0;
        repeat (l) @(posedge i_clk);
        #2;
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (jitter_mode) begin
                check_range("jitter_period", int'(o_period), 8, 10);
                jit_sum   += int'(o_period);
                jit_count += 1;
            end else if (sb.size() == 0) begin
                check_output("unexpected_valid", 1, 0);
            end else begin
                got = sb.pop_front();
                check_output("period", int'(o_period), got.period);
                check_output("high", int'(o_high), got.high);
                check_output("match", int'(o_match), int'(got.match));
                check_output("timeout_low_on_valid", int'(o_timeout), 0);
            end
        end
    end

    initial begin
        #100us;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{3, 4, 4, 7, 3, 1'b1};
        tbl[1] = '{5, 5, 3, 10, 5, 1'b0};
        tbl[2] = '{1, 1, 4, 2, 1, 1'b0};
        tbl[3] = '{4, 3, 3, 7, 4, 1'b1};
        tbl[4] = '{2, 7, 2, 9, 2, 1'b0};
        tbl[5] = '{8, 1, 2, 9, 8, 1'b0};

        checks      = 0;
        fails       = 0;
        armed       = 1'b0;
        jitter_mode = 1'b0;
        jit_sum     = 0;
        jit_count   = 0;
        i_sig       = 1'b0;
        i_rst       = 1'b0;
        #1 i_rst = 1'b1;

        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset_period", int'(o_period), 0);
        check_output("reset_high", int'(o_high), 0);
        check_output("reset_valid", int'(o_valid), 0);
        check_output("reset_match", int'(o_match), 0);
        check_output("reset_timeout", int'(o_timeout), 0);
        @(posedge i_clk);
        #2 i_rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < tbl[r].reps; n++) begin
                apply_stimulus(tbl[r].high, tbl[r].low, tbl[r].exp_period,
                               tbl[r].exp_high, tbl[r].exp_match);
            end
        end

        // Last rise, then silence: timeout lands 20 cycles after the cnt<-1 edge
        apply_stimulus(3, 4, 7, 3, 1'b1);
        if (armed) sb.push_back(pending);
        i_sig = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge i_clk);
            #1;
            if (k == 22) check_output("timeout_not_yet", int'(o_timeout), 0);
            if (k == 23) check_output("timeout_after_20", int'(o_timeout), 1);
            #1;
            if (k == 3) i_sig = 1'b0;
        end
        armed = 1'b0;

        apply_stimulus(3, 4, 7, 3, 1'b1);
        check_output("timeout_sticky_until_valid", int'(o_timeout), 1);
        apply_stimulus(3, 4, 7, 3, 1'b1);
        apply_stimulus(3, 4, 7, 3, 1'b1);
        check_output("timeout_cleared", int'(o_timeout), 0);

        // Asynchronous reset between clock edges
        #1 i_rst = 1'b1;
        #1;
        check_output("async_rst_period", int'(o_period), 0);
        check_output("async_rst_high", int'(o_high), 0);
        check_output("async_rst_match", int'(o_match), 0);
        check_output("async_rst_valid", int'(o_valid), 0);
        check_output("async_rst_timeout", int'(o_timeout), 0);
        armed = 1'b0;
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        for (int n = 0; n < 3; n++) apply_stimulus(4, 3, 7, 4, 1'b1);

        check_output("scoreboard_drained", sb.size(), 0);

        // Period-9 input with edges 1 ns either side of clock edges
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        jitter_mode = 1'b1;
        for (int c = 0; c < 12 * 9; c++) begin
            @(negedge i_clk);
            #4;
            if ((c % 9 == 0) && ((c / 9) % 2 == 1)) i_sig = 1'b1;
            if ((c % 9 == 4) && ((c / 9) % 2 == 0)) i_sig = 1'b0;
            @(posedge i_clk);
            #1;
            if ((c % 9 == 0) && ((c / 9) % 2 == 0)) i_sig = 1'b1;
            if ((c % 9 == 4) && ((c / 9) % 2 == 1)) i_sig = 1'b0;
        end
        repeat (15) @(posedge i_clk);
        #2 jitter_mode = 1'b0;
        check_output("jitter_valid_count", jit_count, 11);
        check_range("jitter_sum", jit_sum, 98, 100);

        repeat (5) @(posedge i_clk);
        check_output("scoreboard_final_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
